// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcodes, flag bit positions and FSM state encoding for seq_alu.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_MOV  = 4'h0;
    localparam logic [3:0] OP_MOVL = 4'h2;
    localparam logic [3:0] OP_MOVH = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_MUL  = 4'h6;
    localparam logic [3:0] OP_DIV  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_XOR  = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;
    localparam logic [3:0] OP_ASR  = 4'hE;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_CARRY   = 1;
    localparam int FLAG_OVF     = 2;
    localparam int FLAG_DIVZERO = 3;
    localparam int FLAG_ILLEGAL = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
// ============================================================================
// Module : seq_alu_muldiv
// Brief  : Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             divzero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic                 r_busy;
    logic                 r_div;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_dvsr;

    logic                 w_div;
    logic                 w_step;
    logic [2*WIDTH-1:0]   w_acc;
    logic [2*WIDTH-1:0]   w_mcand;
    logic [WIDTH-1:0]     w_q;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_dvsr;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;

    // The start cycle performs the first step on the raw operands, so the
    // WIDTH steps complete in exactly WIDTH clock edges.
    assign w_div   = start ? is_div : r_div;
    assign w_acc   = start ? '0 : r_acc;
    assign w_mcand = start ? {{WIDTH{1'b0}}, a} : r_mcand;
    assign w_q     = start ? (is_div ? a : b) : r_q;
    assign w_rem   = start ? '0 : r_rem;
    assign w_dvsr  = start ? b : r_dvsr;
    assign w_shift = {w_rem, w_q[WIDTH-1]};
    assign w_ge    = w_shift >= {1'b0, w_dvsr};
    assign w_step  = start || (r_busy && (r_cnt != CW'(WIDTH)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_div   <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_dvsr  <= '0;
        end else begin
            if (start) begin
                r_busy <= 1'b1;
                r_cnt  <= CW'(1);
                r_div  <= is_div;
                r_dvsr <= b;
            end else if (r_busy) begin
                if (r_cnt == CW'(WIDTH)) begin
                    r_busy <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            if (w_step) begin
                if (w_div) begin
                    // Remainder always fits WIDTH bits once reduced below the divisor.
                    r_rem <= w_ge ? (w_shift[WIDTH-1:0] - w_dvsr) : w_shift[WIDTH-1:0];
                    r_q   <= {w_q[WIDTH-2:0], w_ge};
                end else begin
                    r_acc   <= w_q[0] ? (w_acc + w_mcand) : w_acc;
                    r_mcand <= w_mcand << 1;
                    r_q     <= w_q >> 1;
                end
            end
        end
    end

    assign done     = r_busy && (r_cnt == CW'(WIDTH));
    assign result   = r_div ? r_q : r_acc[WIDTH-1:0];
    assign overflow = !r_div && (|r_acc[2*WIDTH-1:WIDTH]);
    assign divzero  = r_div && (r_dvsr == '0);

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module : seq_alu
// Brief  : Sequential ALU with valid/ready handshake; MUL/DIV iterative engine
//          is built only when SEQ_ALU_MULDIV_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   aluop,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    localparam int HALF = WIDTH / 2;
    localparam int SW   = $clog2(WIDTH);

    state_t             r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [4:0]         r_flags;

    logic [3:0]         w_op;
    logic               w_legal;
    logic [SW-1:0]      w_shamt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH:0]     w_asr;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic               w_illegal;
    logic [4:0]         w_flags;

    assign w_op    = aluop[3:0];
    assign w_legal = (aluop != OPW'(1)) && (aluop < OPW'(15));
    assign w_shamt = val2[SW-1:0];
    assign w_sum   = {1'b0, val1} + {1'b0, val2};
    assign w_diff  = {1'b0, val1} - {1'b0, val2};
    // Extra bit beyond the data catches the last bit shifted out.
    assign w_shl   = {1'b0, val1} << w_shamt;
    assign w_shr   = {val1, 1'b0} >> w_shamt;
    assign w_asr   = $signed({val1, 1'b0}) >>> w_shamt;

    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        if (!w_legal) begin
            w_illegal = 1'b1;
        end else begin
            case (w_op)
                OP_MOV:  w_res = val2;
                OP_MOVL: w_res = {val1[WIDTH-1:HALF], val2[HALF-1:0]};
                OP_MOVH: w_res = {val2[HALF-1:0], val1[HALF-1:0]};
                OP_ADD: begin
                    w_res   = w_sum[WIDTH-1:0];
                    w_carry = w_sum[WIDTH];
                    w_ovf   = (val1[WIDTH-1] == val2[WIDTH-1]) && (w_sum[WIDTH-1] != val1[WIDTH-1]);
                end
                OP_SUB: begin
                    w_res   = w_diff[WIDTH-1:0];
                    w_carry = w_diff[WIDTH];
                    w_ovf   = (val1[WIDTH-1] != val2[WIDTH-1]) && (w_diff[WIDTH-1] != val1[WIDTH-1]);
                end
                OP_AND:  w_res = val1 & val2;
                OP_OR:   w_res = val1 | val2;
                OP_NOT:  w_res = ~val1;
                OP_XOR:  w_res = val1 ^ val2;
                OP_SHL: begin
                    w_res   = w_shl[WIDTH-1:0];
                    w_carry = w_shl[WIDTH];
                end
                OP_SHR: begin
                    w_res   = w_shr[WIDTH:1];
                    w_carry = w_shr[0];
                end
                OP_ASR: begin
                    w_res   = w_asr[WIDTH:1];
                    w_carry = w_asr[0];
                end
                // MUL/DIV reach this path only when the engine is not built.
                default: w_illegal = 1'b1;
            endcase
        end
        w_flags               = '0;
        w_flags[FLAG_ZERO]    = !w_illegal && (w_res == '0);
        w_flags[FLAG_CARRY]   = w_carry;
        w_flags[FLAG_OVF]     = w_ovf;
        w_flags[FLAG_ILLEGAL] = w_illegal;
    end

`ifdef SEQ_ALU_MULDIV_EN
    logic             w_start;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_result;
    logic             w_md_ovf;
    logic             w_md_divzero;
    logic [4:0]       w_md_flags;

    assign w_start = (r_state == IDLE) && in_valid && w_legal && is_muldiv(w_op);

    seq_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .is_div   (w_op == OP_DIV),
        .a        (val1),
        .b        (val2),
        .done     (w_md_done),
        .result   (w_md_result),
        .overflow (w_md_ovf),
        .divzero  (w_md_divzero)
    );

    always_comb begin
        w_md_flags               = '0;
        w_md_flags[FLAG_ZERO]    = (w_md_result == '0);
        w_md_flags[FLAG_OVF]     = w_md_ovf;
        w_md_flags[FLAG_DIVZERO] = w_md_divzero;
    end
`else
    logic w_start;
    assign w_start = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= CALC;
                    end else if (in_valid) begin
                        r_state     <= HOLD;
                        r_result    <= w_res;
                        r_flags     <= w_flags;
                        r_out_valid <= 1'b1;
                    end
                end
`ifdef SEQ_ALU_MULDIV_EN
                CALC: begin
                    if (w_md_done) begin
                        r_state     <= HOLD;
                        r_result    <= w_md_result;
                        r_flags     <= w_md_flags;
                        r_out_valid <= 1'b1;
                    end
                end
`endif
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; even, >= 8.
REQ-002 SHALL have parameter OPW, default 5, opcode width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port aluop  input  OPW  operation code.
REQ-008 SHALL have ports val1, val2  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have port flags  output  5  {illegal, divzero, overflow, carry, zero}.

Function
REQ-013 SHALL accept a request on a rising edge where in_valid and in_ready are both high; operands and opcode are captured at that edge.
REQ-014 SHALL use FSM states IDLE, CALC, HOLD; in_ready = (state==IDLE).
REQ-015 IDLE + accept of a single-cycle op SHALL go to HOLD with result registered (out_valid at accept edge + 1).
REQ-016 IDLE + accept of MUL or DIV SHALL go to CALC for exactly WIDTH cycles, then to HOLD (out_valid at accept edge + WIDTH + 1).
REQ-017 HOLD SHALL keep result/flags stable and out_valid high until out_ready is high on an edge, then return to IDLE.
REQ-018 Opcodes: MOV=0 val2; MOVL=2 {val1 upper half, val2 lower half}; MOVH=3 {val2 lower half, val1 lower half}; ADD=4; SUB=5 val1-val2; MUL=6 low WIDTH bits of product; DIV=7 unsigned quotient val1/val2; AND=8; OR=9; NOT=A ~val1; XOR=B; SHL=C; SHR=D logical; ASR=E arithmetic.
REQ-019 Shift amount SHALL be val2[$clog2(WIDTH)-1:0]; upper val2 bits ignored.
REQ-020 MUL SHALL be iterative shift-add, one val2 bit per CALC cycle; DIV SHALL be restoring, one quotient bit per CALC cycle.
REQ-021 zero SHALL be (result==0) for every op.
REQ-022 carry SHALL be carry-out for ADD, borrow for SUB, last bit shifted out for SHL/SHR/ASR (0 when amount 0), else 0.
REQ-023 overflow SHALL be signed overflow for ADD/SUB, (product high WIDTH bits != 0) for MUL, else 0.
REQ-024 DIV with val2==0 SHALL still take WIDTH CALC cycles, give result all-ones and divzero=1.
REQ-025 Opcodes 1 and F..(2^OPW-1) SHALL complete as single-cycle with result 0, illegal=1, other flags 0.
REQ-026 Requests presented while in_ready is low SHALL be ignored, not queued.

Reset
REQ-027 rst high on an edge SHALL force IDLE, out_valid=0, result=0, flags=0, in_ready=1 next cycle, from any state.
REQ-028 rst during CALC or HOLD SHALL discard the in-flight operation; no result is produced for it.

Configuration
REQ-029 Macro SEQ_ALU_MULDIV_EN defined: MUL/DIV behave per REQ-016..REQ-024.
REQ-030 Macro SEQ_ALU_MULDIV_EN undefined: MUL/DIV SHALL be treated as illegal per REQ-025, no CALC state entered, iterative engine not instantiated.

Structure
REQ-031 Opcode localparams, flag bit indices and FSM state encodings SHALL live in shared package alu_pkg.
REQ-032 Iterative MUL/DIV datapath SHALL be sub-module seq_alu_muldiv (start/done, WIDTH-parametrised); FSM and single-cycle ops stay in seq_alu.

Verification (WIDTH=32)
REQ-033 ADD 0xFFFFFFFF+0x1 -> result 0x0, zero=1, carry=1, out_valid 1 cycle after accept.
REQ-034 SUB 0x80000000-0x1 -> 0x7FFFFFFF, overflow=1, carry=0.
REQ-035 MUL 0x10000*0x10001 -> 0x10000, overflow=1; DIV 100/7 -> 14; both out_valid exactly 33 cycles after accept, in_ready low throughout.
REQ-036 DIV 5/0 -> 0xFFFFFFFF, divzero=1; aluop 0x1F -> 0x0, illegal=1.
REQ-037 out_ready held low 10 cycles after ADD 3+4 -> result 7 stable, out_valid high, new in_valid ignored; out_ready high -> IDLE next cycle.
REQ-038 rst asserted 5 cycles into DIV -> out_valid 0, in_ready 1 next cycle; following AND 0xF0&0x3C -> 0x30.
